// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    // Synchronized row pattern when no key pulls a row low.
    localparam logic [3:0] ROWS_IDLE = 4'hF;

    // Result of decoding a row pattern: index of the low bit and whether exactly one bit was low.
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } row_hit_t;

    // Returns the index of the single low bit; valid is 0 for idle or multi-key patterns.
    function automatic row_hit_t onehot0_idx(input logic [3:0] rows);
        row_hit_t hit;
        hit.valid = 1'b1;
        hit.idx   = 2'd0;
        case (rows)
            4'b1110: hit.idx = 2'd0;
            4'b1101: hit.idx = 2'd1;
            4'b1011: hit.idx = 2'd2;
            4'b0111: hit.idx = 2'd3;
            default: hit.valid = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles high.
module row_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] rs
);

    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            // Each row bit gets its own two-stage chain, reset to the released level.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg[gi] <= 1'b1;
                    sync2_reg[gi] <= 1'b1;
                end else begin
                    sync1_reg[gi] <= row[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    assign rs = sync2_reg;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, press/release debounce,
// key strobe and an 8-digit entry shift register.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_BITS       = 17,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] value
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The strobe/exit is registered on the cycle the count would reach DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SCAN_BITS-1:0] div_reg;
    logic                 tick;
    logic [3:0]           rs;
    row_hit_t             hit;

    kp_state_t   state_reg, state_next;
    logic [1:0]  col_idx_reg, col_idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]  pat_reg, pat_next;
    logic [3:0]  cand_reg, cand_next;
    logic        skip_reg, skip_next;
    logic        key_valid_reg, key_valid_next;
    logic [3:0]  key_code_reg, key_code_next;
    logic [31:0] value_reg, value_next;
    logic        shift;

    row_sync u_row_sync (
        .clk   (clk),
        .reset (reset),
        .row   (row),
        .rs    (rs)
    );

    assign tick = &div_reg;
    assign hit  = onehot0_idx(rs);

    // Free-running dwell divider; only reset restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + SCAN_BITS'(1);
        end
    end

    // Next-state logic for scan, debounce and hold handling.
    always_comb begin
        state_next     = state_reg;
        col_idx_next   = col_idx_reg;
        cnt_next       = cnt_reg;
        pat_next       = pat_reg;
        cand_next      = cand_reg;
        skip_next      = skip_reg;
        key_valid_next = 1'b0;
        key_code_next  = key_code_reg;
        shift          = 1'b0;
        case (state_reg)
            SCAN: begin
                if (tick) begin
                    if (skip_reg) begin
                        // After a bounce the frozen column is passed over once,
                        // so scanning resumes from the next column.
                        skip_next    = 1'b0;
                        col_idx_next = col_idx_reg + 2'd1;
                    end else if (hit.valid) begin
                        pat_next   = rs;
                        cand_next  = {hit.idx, col_idx_reg};
                        cnt_next   = CNT_W'(1);
                        state_next = DEBOUNCE;
                    end else begin
                        col_idx_next = col_idx_reg + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (rs == pat_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        key_valid_next = 1'b1;
                        key_code_next  = cand_reg;
                        shift          = 1'b1;
                        cnt_next       = '0;
                        state_next     = HELD;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else begin
                    cnt_next   = '0;
                    skip_next  = 1'b1;
                    state_next = SCAN;
                end
            end
            HELD: begin
                if (rs == ROWS_IDLE) begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = SCAN;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            default: begin
                state_next = SCAN;
                cnt_next   = '0;
            end
        endcase

        // clear wins over a same-cycle digit shift.
        value_next = value_reg;
        if (clear) begin
            value_next = '0;
        end else if (shift) begin
            value_next = {value_reg[27:0], cand_reg};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SCAN;
            col_idx_reg   <= 2'd0;
            cnt_reg       <= '0;
            pat_reg       <= ROWS_IDLE;
            cand_reg      <= 4'd0;
            skip_reg      <= 1'b0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'd0;
            value_reg     <= 32'd0;
        end else begin
            state_reg     <= state_next;
            col_idx_reg   <= col_idx_next;
            cnt_reg       <= cnt_next;
            pat_reg       <= pat_next;
            cand_reg      <= cand_next;
            skip_reg      <= skip_next;
            key_valid_reg <= key_valid_next;
            key_code_reg  <= key_code_next;
            value_reg     <= value_next;
        end
    end

    assign col       = ~(4'b0001 << col_idx_reg);
    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign value     = value_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 keypad.
module tb_keypad_scan;

    logic        clk;
    logic        reset;
    logic [3:0]  row;
    logic        clear;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] value;

    logic [15:0] keys;        // bit r*4+c pressed
    logic [3:0]  bounce_low;  // direct row pull-downs
    int          errors = 0;
    int          checks = 0;
    int          strobes = 0;
    logic        prev_kv = 1'b0;
    logic [3:0]  prev_col = 4'hE;
    logic [3:0]  scan_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    keypad_scan #(
        .SCAN_BITS       (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .clear     (clear),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .value     (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
            if (bounce_low[r]) row[r] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        while (key_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Wait until col changes into target (or any change when any_change is set).
    task automatic wait_col(input logic [3:0] target, input bit any_change, input int limit, output bit ok);
        logic [3:0] last;
        last = col;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (col != last && (any_change || col == target)) ok = 1'b1;
            last = col;
        end
    endtask

    // Strobe monitor: one line per accepted key, pulse width and column sanity.
    always @(negedge clk) begin
        if (!reset && key_valid) begin
            strobes <= strobes + 1;
            $display("key code=%h value=%h", key_code, value);
            check("kv_pulse", {31'd0, prev_kv}, 32'd0);
        end
        if (col != prev_col) check("col_onehot", $countones(~col), 32'd1);
        prev_kv  <= key_valid;
        prev_col <= col;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        bit ok;
        logic [3:0]  c0;
        logic [3:0]  c_next;
        logic [31:0] v_before;

        reset = 1'b1; clear = 1'b0; keys = '0; bounce_low = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_col", {28'd0, col}, 32'hE);
        check("rst_kv", {31'd0, key_valid}, 32'd0);
        check("rst_code", {28'd0, key_code}, 32'd0);
        check("rst_value", value, 32'd0);

        // Column stepping every 8 cycles.
        for (int i = 0; i < 4; i++) begin
            repeat (7) @(negedge clk);
            check("scan_hold", {28'd0, col}, {28'd0, scan_seq[i]});
            @(negedge clk);
            check("scan_step", {28'd0, col}, {28'd0, scan_seq[(i+1)%4]});
        end

        // Single press of (1,2): strobe 4 cycles after the detect tick.
        base = strobes;
        keys[1*4+2] = 1'b1;
        wait_col(4'hB, 1'b0, 40, ok);
        check("sp_colwait", {31'd0, ok}, 32'd1);
        wait_strobe(20, n);
        check("sp_latency", n, 11);
        check("sp_code", {28'd0, key_code}, 32'h6);
        check("sp_value", value, 32'h6);
        repeat (30) @(negedge clk);
        check("sp_frozen", {28'd0, col}, 32'hB);
        keys = '0;
        repeat (30) @(negedge clk);
        check("sp_count", strobes - base, 1);

        // Clear, then enter digits 1..9 and watch the register wrap.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_value", value, 32'd0);
        for (int k = 1; k <= 9; k++) begin
            keys[k] = 1'b1;
            wait_strobe(60, n);
            check("entry_seen", {31'd0, key_valid}, 32'd1);
            check("entry_code", {28'd0, key_code}, k);
            repeat (5) @(negedge clk);
            keys = '0;
            repeat (40) @(negedge clk);
            if (k == 3) check("entry_3", value, 32'h123);
        end
        check("entry_9", value, 32'h23456789);

        // Two-cycle glitch on row 0 caught at a tick: no strobe, scan resumes.
        base = strobes;
        wait_col(4'h0, 1'b1, 20, ok);
        c0 = col;
        c_next = {c0[2:0], c0[3]};
        repeat (5) @(negedge clk);
        bounce_low = 4'b0001;
        repeat (2) @(negedge clk);
        bounce_low = 4'b0000;
        wait_col(4'h0, 1'b1, 20, ok);
        check("bnc_resume", {31'd0, ok}, 32'd1);
        check("bnc_nextcol", {28'd0, col}, {28'd0, c_next});
        repeat (10) @(negedge clk);
        check("bnc_nostrobe", strobes - base, 0);

        // Short release while held must not yield a second strobe.
        base = strobes;
        keys[15] = 1'b1;
        wait_strobe(60, n);
        check("held_code", {28'd0, key_code}, 32'hF);
        repeat (5) @(negedge clk);
        keys = '0;
        repeat (2) @(negedge clk);
        keys[15] = 1'b1;
        repeat (10) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        check("held_count", strobes - base, 1);
        check("held_value", value, 32'h3456789F);

        // Ghost: two keys on column 1 give two low rows and are ignored.
        base = strobes;
        v_before = value;
        keys[0*4+1] = 1'b1;
        keys[2*4+1] = 1'b1;
        wait_col(4'hD, 1'b0, 40, ok);
        check("ghost_colwait", {31'd0, ok}, 32'd1);
        check("ghost_rows", {28'd0, row}, 32'hA);
        repeat (50) @(negedge clk);
        check("ghost_nostrobe", strobes - base, 0);
        check("ghost_value", value, v_before);
        keys = '0;
        repeat (10) @(negedge clk);

        // clear coinciding with the shift of key 5.
        base = strobes;
        wait_col(4'hE, 1'b0, 40, ok);
        keys[5] = 1'b1;
        wait_col(4'hD, 1'b0, 20, ok);
        check("clr5_colwait", {31'd0, ok}, 32'd1);
        repeat (10) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr5_kv", {31'd0, key_valid}, 32'd1);
        check("clr5_code", {28'd0, key_code}, 32'h5);
        check("clr5_value", value, 32'd0);
        repeat (5) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        check("clr5_count", strobes - base, 1);

        // Reset two cycles into debounce of key 2.
        wait_col(4'hE, 1'b0, 40, ok);
        keys[2] = 1'b1;
        wait_col(4'hB, 1'b0, 20, ok);
        check("rstdb_colwait", {31'd0, ok}, 32'd1);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        keys = '0;
        base = strobes;
        check("rstdb_col", {28'd0, col}, 32'hE);
        check("rstdb_kv", {31'd0, key_valid}, 32'd0);
        check("rstdb_code", {28'd0, key_code}, 32'd0);
        check("rstdb_value", value, 32'd0);
        repeat (30) @(negedge clk);
        check("rstdb_nostrobe", strobes - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
